// File: rtl/egress_tlp_arb.sv
`default_nettype none
// egress_tlp_arb: packet-atomic round-robin merge of cpl/rdreq/wrreq TLP streams onto the core TX stream.
// Rev 1.0
module egress_tlp_arb #(
  parameter int DATA_W = 128,
  parameter int KEEP_W = 16,
  parameter int N_SRC  = 3,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_SRC*DATA_W-1:0] s_tdata,
  input  logic [N_SRC*KEEP_W-1:0] s_tkeep,
  input  logic [N_SRC-1:0]        s_sop,
  input  logic [N_SRC-1:0]        s_eop,
  input  logic [N_SRC-1:0]        s_tvalid,
  output logic [N_SRC-1:0]        s_tready,
  output logic [DATA_W-1:0]       m_axis_tx_tdata,
  output logic [KEEP_W-1:0]       m_axis_tx_tkeep,
  output logic                    m_axis_tx_sop,
  output logic                    m_axis_tx_eop,
  output logic                    m_axis_tx_tvalid,
  input  logic                    m_axis_tx_tready,
  output logic [N_SRC*CNT_W-1:0]  pkt_cnt,
  output logic                    busy
);

  localparam int GW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   pick;
  logic            pick_vld;
  logic [N_SRC-1:0] eligible;
  logic            out_ready;
  logic            accept;
  logic            pkt_end;

  assign eligible  = s_tvalid & s_sop;
  assign out_ready = ~m_axis_tx_tvalid | m_axis_tx_tready;
  assign accept    = (state == XFER) && s_tvalid[grant] && out_ready;
  assign pkt_end   = accept && s_eop[grant];
  assign busy      = (state == XFER);

  // Rotating priority: the search starts just after the previous winner.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 1; k <= N_SRC; k++) begin
      if (!pick_vld && eligible[(int'(last_grant) + k) % N_SRC]) begin
        pick     = GW'((int'(last_grant) + k) % N_SRC);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = XFER;
      XFER:    if (pkt_end)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_tready = '0;
    if (state == XFER) s_tready[grant] = out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(N_SRC - 1);
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_vld) begin
        grant      <= pick;
        last_grant <= pick;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tx_tdata  <= '0;
      m_axis_tx_tkeep  <= '0;
      m_axis_tx_sop    <= 1'b0;
      m_axis_tx_eop    <= 1'b0;
      m_axis_tx_tvalid <= 1'b0;
    end else if (accept) begin
      m_axis_tx_tdata  <= s_tdata[int'(grant)*DATA_W +: DATA_W];
      m_axis_tx_tkeep  <= s_tkeep[int'(grant)*KEEP_W +: KEEP_W];
      m_axis_tx_sop    <= s_sop[grant];
      m_axis_tx_eop    <= s_eop[grant];
      m_axis_tx_tvalid <= 1'b1;
    end else if (m_axis_tx_tready) begin
      m_axis_tx_tvalid <= 1'b0;
    end
  end

  // Counters advance when the eop beat is accepted, not when it leaves the output register.
  for (genvar i = 0; i < N_SRC; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
      end else if (pkt_end && grant == GW'(i) && cnt != {CNT_W{1'b1}}) begin
        cnt <= cnt + 1'b1;
      end
    end
    assign pkt_cnt[i*CNT_W +: CNT_W] = cnt;
  end

endmodule
`default_nettype wire

// File: tb/tb_egress_tlp_arb.sv
`default_nettype none
// tb_egress_tlp_arb: directed stimulus with a packet-level round-robin scoreboard for egress_tlp_arb.
// Rev 1.0
module tb_egress_tlp_arb;

  localparam int DATA_W = 128;
  localparam int KEEP_W = 16;
  localparam int N_SRC  = 3;
  localparam int CNT_W  = 4;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              sop;
    logic              eop;
  } beat_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_SRC*DATA_W-1:0] s_tdata;
  logic [N_SRC*KEEP_W-1:0] s_tkeep;
  logic [N_SRC-1:0]        s_sop, s_eop, s_tvalid, s_tready;
  logic [DATA_W-1:0]       m_tdata;
  logic [KEEP_W-1:0]       m_tkeep;
  logic                    m_sop, m_eop, m_tvalid, m_tready;
  logic [N_SRC*CNT_W-1:0]  pkt_cnt;
  logic                    busy;

  egress_tlp_arb #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .N_SRC(N_SRC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_sop(s_sop), .s_eop(s_eop),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_axis_tx_tdata(m_tdata), .m_axis_tx_tkeep(m_tkeep),
    .m_axis_tx_sop(m_sop), .m_axis_tx_eop(m_eop),
    .m_axis_tx_tvalid(m_tvalid), .m_axis_tx_tready(m_tready),
    .pkt_cnt(pkt_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  beat_t dq[N_SRC][$];    // beats still to be offered by each source
  beat_t pend[N_SRC][$];  // beats the scoreboard still expects at the output
  int    sop_log[$];
  int    hs_cyc[$];
  int    cnt_m[N_SRC];
  int    last_m;
  int    open_m;
  int    cyc = 0;

  task automatic chk(input bit ok, input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_pkt(input int src, input int nb, input logic [DATA_W-1:0] base);
    beat_t b;
    for (int k = 0; k < nb; k++) begin
      b.data = base + DATA_W'(k);
      b.keep = 16'hFFFF >> k;
      b.sop  = (k == 0);
      b.eop  = (k == nb - 1);
      dq[src].push_back(b);
      pend[src].push_back(b);
    end
  endtask

  task automatic flush_all();
    for (int i = 0; i < N_SRC; i++) begin
      dq[i].delete();
      pend[i].delete();
    end
    sop_log.delete();
    hs_cyc.delete();
  endtask

  function automatic bit queues_empty();
    bit e = 1'b1;
    for (int i = 0; i < N_SRC; i++)
      if (dq[i].size() != 0 || pend[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic drain();
    int n = 0;
    while ((!queues_empty() || m_tvalid || busy) && n < 400) begin
      tick();
      n++;
    end
    chk(n < 400, "drain_timeout", 160'(n), 160'(400));
    for (int i = 0; i < N_SRC; i++)
      chk(pkt_cnt[i*CNT_W +: CNT_W] == CNT_W'(cnt_m[i] > 15 ? 15 : cnt_m[i]), "pkt_cnt_model",
          160'(pkt_cnt[i*CNT_W +: CNT_W]), 160'(cnt_m[i] > 15 ? 15 : cnt_m[i]));
  endtask

  function automatic int rr_pick();
    for (int k = 1; k <= N_SRC; k++)
      if (pend[(last_m + k) % N_SRC].size() != 0) return (last_m + k) % N_SRC;
    return -1;
  endfunction

  // Source drivers: offer the head beat of each queue, drop it once handshaken.
  initial begin
    logic [N_SRC-1:0] fire;
    beat_t b;
    s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_sop = '0; s_eop = '0;
    forever begin
      @(negedge clk);
      fire = s_tvalid & s_tready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N_SRC; i++) begin
        if (fire[i] && dq[i].size() != 0) void'(dq[i].pop_front());
        if (dq[i].size() != 0) begin
          b = dq[i][0];
          s_tvalid[i] = 1'b1;
          s_tdata[i*DATA_W +: DATA_W] = b.data;
          s_tkeep[i*KEEP_W +: KEEP_W] = b.keep;
          s_sop[i] = b.sop;
          s_eop[i] = b.eop;
        end else begin
          s_tvalid[i] = 1'b0;
          s_sop[i] = 1'b0;
          s_eop[i] = 1'b0;
        end
      end
    end
  end

  // Scoreboard: every output handshake must be the next beat of the packet owner,
  // owners chosen round-robin among sources with packets waiting.
  initial begin
    bit    prev_hold = 1'b0;
    logic [DATA_W+KEEP_W+1:0] prev_out = '0;
    beat_t exp;
    int    src;
    last_m = N_SRC - 1;
    open_m = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        open_m = -1;
        last_m = N_SRC - 1;
        for (int i = 0; i < N_SRC; i++) cnt_m[i] = 0;
        prev_hold = 1'b0;
      end else begin
        chk($onehot0(s_tready), "s_tready_onehot", 160'(s_tready), 160'(0));
        if (!busy) chk(s_tready == '0, "s_tready_idle", 160'(s_tready), 160'(0));
        if (prev_hold)
          chk({m_tdata, m_tkeep, m_sop, m_eop} == prev_out && m_tvalid, "hold_stable",
              160'({m_tdata, m_tkeep, m_sop, m_eop}), 160'(prev_out));
        if (m_tvalid && m_tready) begin
          src = (open_m < 0) ? rr_pick() : open_m;
          if (src < 0 || pend[src].size() == 0) begin
            chk(1'b0, "unexpected_beat", 160'(m_tdata), 160'(0));
          end else begin
            exp = pend[src].pop_front();
            chk({m_tdata, m_tkeep, m_sop, m_eop} == exp, "out_beat",
                160'({m_tdata, m_tkeep, m_sop, m_eop}), 160'(exp));
            if (exp.sop) begin
              last_m = src;
              sop_log.push_back(src);
            end
            if (exp.eop) begin
              open_m = -1;
              cnt_m[src]++;
            end else begin
              open_m = src;
            end
            hs_cyc.push_back(cyc);
          end
        end
        prev_hold = m_tvalid && !m_tready;
        prev_out  = {m_tdata, m_tkeep, m_sop, m_eop};
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order[6];
    int n;
    beat_t b;
    exp_order = '{0, 1, 2, 0, 1, 2};
    rst = 1'b1;
    m_tready = 1'b1;
    tick();
    tick();
    flush_all();
    rst = 1'b0;

    // Reset state
    chk({m_tvalid, m_sop, m_eop} == 3'b000, "rst_out_ctrl", 160'({m_tvalid, m_sop, m_eop}), 160'(0));
    chk(m_tdata == '0 && m_tkeep == '0, "rst_out_data", 160'(m_tdata), 160'(0));
    chk(s_tready == '0 && !busy && pkt_cnt == '0, "rst_misc", 160'({pkt_cnt, s_tready, busy}), 160'(0));

    // Single 3-beat packet from source 1, cycle-exact
    push_pkt(1, 3, 128'hA0);
    tick();
    chk(!busy && s_tready == 3'b000, "t1_idle", 160'({busy, s_tready}), 160'(0));
    tick();
    chk(busy && s_tready == 3'b010 && !m_tvalid, "t1_grant", 160'({busy, s_tready, m_tvalid}), 160'(5'b1_010_0));
    tick();
    chk(m_tvalid && m_tdata == 128'hA0 && m_sop && !m_eop && m_tkeep == 16'hFFFF, "t1_beat0",
        160'({m_tdata[7:0], m_tkeep, m_sop, m_eop}), 160'({8'hA0, 16'hFFFF, 2'b10}));
    tick();
    chk(m_tvalid && m_tdata == 128'hA1 && !m_sop && !m_eop && m_tkeep == 16'h7FFF, "t1_beat1",
        160'({m_tdata[7:0], m_tkeep, m_sop, m_eop}), 160'({8'hA1, 16'h7FFF, 2'b00}));
    tick();
    chk(m_tvalid && m_tdata == 128'hA2 && !m_sop && m_eop && !busy, "t1_beat2",
        160'({m_tdata[7:0], m_sop, m_eop, busy}), 160'({8'hA2, 3'b010}));
    chk(pkt_cnt[1*CNT_W +: CNT_W] == 4'd1, "t1_cnt", 160'(pkt_cnt[1*CNT_W +: CNT_W]), 160'(1));
    drain();

    // Three sources contending, two 2-beat packets each
    rst = 1'b1; tick(); flush_all(); rst = 1'b0;
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < N_SRC; s++) push_pkt(s, 2, DATA_W'(s * 4096 + p * 256));
    drain();
    chk(sop_log.size() == 6, "t2_npkts", 160'(sop_log.size()), 160'(6));
    for (int k = 0; k < 6 && k < sop_log.size(); k++)
      chk(sop_log[k] == exp_order[k], "t2_order", 160'(sop_log[k]), 160'(exp_order[k]));
    chk(hs_cyc.size() == 12 && hs_cyc[hs_cyc.size()-1] - hs_cyc[0] == 16, "t2_span",
        160'(hs_cyc.size() == 0 ? 0 : hs_cyc[hs_cyc.size()-1] - hs_cyc[0]), 160'(16));

    // Source 0 raises sop while source 2 is mid-packet
    sop_log.delete(); hs_cyc.delete();
    push_pkt(2, 4, 128'h2_0000);
    repeat (4) tick();
    push_pkt(0, 2, 128'h0_5000);
    tick();
    chk(s_tready == 3'b100 && busy, "t3_no_preempt", 160'({s_tready, busy}), 160'(4'b100_1));
    drain();
    chk(sop_log.size() == 2 && sop_log[0] == 2 && sop_log[1] == 0, "t3_order",
        160'(sop_log.size() == 2 ? sop_log[0] * 16 + sop_log[1] : 255), 160'(8'h20));

    // Output backpressure 1,0,0,1 during a 4-beat packet
    sop_log.delete(); hs_cyc.delete();
    push_pkt(1, 4, 128'h1_7000);
    n = 0;
    while (!m_tvalid && n < 10) begin tick(); n++; end
    chk(n < 10, "t4_start_timeout", 160'(n), 160'(10));
    tick();
    m_tready = 1'b0;
    #1;
    chk(m_tdata == 128'h1_7001 && s_tready == 3'b000, "t4_hold0", 160'({m_tdata[15:0], s_tready}), 160'({16'h7001, 3'b000}));
    tick();
    chk(m_tdata == 128'h1_7001 && m_tvalid && s_tready == 3'b000, "t4_hold1", 160'({m_tdata[15:0], s_tready}), 160'({16'h7001, 3'b000}));
    tick();
    m_tready = 1'b1;
    drain();
    chk(hs_cyc.size() == 4, "t4_beats", 160'(hs_cyc.size()), 160'(4));

    // Valid without sop in IDLE never wins
    rst = 1'b1; tick(); flush_all(); rst = 1'b0;
    b.data = 128'hDEAD; b.keep = 16'hFFFF; b.sop = 1'b0; b.eop = 1'b0;
    dq[1].push_back(b);
    repeat (10) begin
      tick();
      chk({busy, s_tready, m_tvalid} == 5'b0, "t5_no_grant", 160'({busy, s_tready, m_tvalid}), 160'(0));
    end

    // Reset during beat 2 of 4, then first grant and counter saturation
    rst = 1'b1; tick(); flush_all(); rst = 1'b0;
    push_pkt(1, 4, 128'h1_9000);
    n = 0;
    while (!(m_tvalid && m_sop) && n < 10) begin tick(); n++; end
    chk(n < 10, "t6_start_timeout", 160'(n), 160'(10));
    tick();
    rst = 1'b1;
    tick();
    chk({m_tvalid, m_sop, m_eop, busy, s_tready} == '0 && m_tdata == '0 && m_tkeep == '0 && pkt_cnt == '0,
        "t6_reset_out", 160'({pkt_cnt, m_tdata[15:0], m_tvalid, busy, s_tready}), 160'(0));
    flush_all();
    rst = 1'b0;
    push_pkt(1, 2, 128'h1_A000);
    push_pkt(0, 2, 128'h0_A000);
    drain();
    chk(sop_log.size() == 2 && sop_log[0] == 0 && sop_log[1] == 1, "t6_first_grant",
        160'(sop_log.size() == 2 ? sop_log[0] * 16 + sop_log[1] : 255), 160'(8'h01));
    for (int p = 0; p < 20; p++) push_pkt(2, 1, DATA_W'(32'h2_B000 + p * 16));
    drain();
    chk(pkt_cnt[2*CNT_W +: CNT_W] == 4'd15, "t6_saturate", 160'(pkt_cnt[2*CNT_W +: CNT_W]), 160'(15));
    chk(pkt_cnt[0*CNT_W +: CNT_W] == 4'd1, "t6_cnt0", 160'(pkt_cnt[0*CNT_W +: CNT_W]), 160'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
